// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: merges ALU and load-unit writebacks into one
// registered write port. Define RF_WB_ARB_RR_EN for round-robin; default is MEM fixed priority with ALU starvation guard.
module rf_wb_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [2:0]  alu_reg,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [2:0]  mem_reg,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        write_en,
    output logic [2:0]  write_reg,
    output logic [31:0] write_data,
    output logic [7:0]  busy_mask
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
        $error("rf_wb_arbiter: STARVE_MAX must be within 1..15");
    end

    logic        alu_wins;
    logic        alu_fire;
    logic        mem_fire;
    logic        write_en_reg;
    logic [2:0]  write_reg_reg;
    logic [31:0] write_data_reg;

`ifdef RF_WB_ARB_RR_EN
    // Pointer names the preferred source on a contest: 0 = ALU, 1 = MEM.
    logic rr_ptr_reg;

    assign alu_wins = ~rr_ptr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= 1'b0;
        end else if (alu_fire && mem_valid) begin
            rr_ptr_reg <= 1'b1;
        end else if (mem_fire && alu_valid) begin
            rr_ptr_reg <= 1'b0;
        end
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    // Counts ALU losses since its last grant; reaching the limit flips the next contest.
    logic [3:0] starve_cnt_reg;

    assign alu_wins = (starve_cnt_reg == STARVE_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_reg <= 4'd0;
        end else if (alu_fire) begin
            starve_cnt_reg <= 4'd0;
        end else if (alu_valid && (starve_cnt_reg < STARVE_LIM)) begin
            starve_cnt_reg <= starve_cnt_reg + 4'd1;
        end
    end
`endif

    assign alu_ready = ~rst & alu_valid & (~mem_valid | alu_wins);
    assign mem_ready = ~rst & mem_valid & (~alu_valid | ~alu_wins);
    assign alu_fire  = alu_ready;
    assign mem_fire  = mem_ready;

    // Output stage accepts every cycle; reg/data hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_en_reg   <= 1'b0;
            write_reg_reg  <= 3'd0;
            write_data_reg <= 32'd0;
        end else begin
            write_en_reg <= alu_fire | mem_fire;
            if (alu_fire) begin
                write_reg_reg  <= alu_reg;
                write_data_reg <= alu_data;
            end else if (mem_fire) begin
                write_reg_reg  <= mem_reg;
                write_data_reg <= mem_data;
            end
        end
    end

    assign write_en   = write_en_reg;
    assign write_reg  = write_reg_reg;
    assign write_data = write_data_reg;

    for (genvar gi = 0; gi < 8; gi++) begin : g_busy
        assign busy_mask[gi] = write_en_reg && (write_reg_reg == 3'(gi));
    end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
- REQ-001: Parameter STARVE_MAX, default 3: number of consecutive lost arbitrations the ALU source tolerates in fixed-priority mode (legal range 1..15).
- REQ-002: Clocking: one clock; reset is synchronous and active-high.
- REQ-003: clk  input  1  rising-edge clock for all state.
- REQ-004: rst  input  1  synchronous active-high reset.
- REQ-005: alu_valid  input  1  ALU writeback request present.
- REQ-006: alu_reg  input  3  ALU destination register index.
- REQ-007: alu_data  input  32  ALU writeback data.
- REQ-008: alu_ready  output  1  ALU request accepted this cycle.
- REQ-009: mem_valid  input  1  load-unit writeback request present.
- REQ-010: mem_reg  input  3  load-unit destination register index.
- REQ-011: mem_data  input  32  load-unit writeback data.
- REQ-012: mem_ready  output  1  load-unit request accepted this cycle.
- REQ-013: write_en  output  1  register-file write strobe, registered.
- REQ-014: write_reg  output  3  register-file write index, registered.
- REQ-015: write_data  output  32  register-file write data, registered.
- REQ-016: busy_mask  output  8  one-hot of write_reg when write_en=1, else 0; used by decode for hazard stall.

Function
- REQ-017: Transfer on a source occurs when its valid and ready are both 1 in the same cycle; at most one transfer per cycle.
- REQ-018: Ready is combinational from valids and arbiter state; a source with valid=0 never sees ready=1.
- REQ-019: A single valid requester is granted immediately, whatever the arbiter state.
- REQ-020: A granted transfer appears on write_en/write_reg/write_data exactly one cycle later (latency 1); write_en=0 in any cycle following a no-transfer cycle.
- REQ-021: The output stage never back-pressures: a new transfer may be accepted every cycle.
- REQ-022: A requester that loses arbitration holds valid, reg and data stable until granted; the block does not buffer the loser.
- REQ-023: Both requests targeting the same register are not merged; each is written in grant order, so the last-granted data persists.
- REQ-024: write_reg and write_data hold their last values when write_en=0.
- REQ-025: busy_mask is derived from the registered output stage only, never from inputs.

Reset
- REQ-026: While rst=1 at a rising edge: write_en=0, write_reg=0, write_data=0, busy_mask=0, round-robin pointer=ALU, starvation counter=0.
- REQ-027: alu_ready and mem_ready are 0 in any cycle where rst=1; a request presented during reset is not accepted and must be re-presented.
- REQ-028: Reset asserted while a write is in the output stage discards that write; write_en=0 in the next cycle.

Configuration
- REQ-029: Macro RF_WB_ARB_RR_EN defined: round-robin; the pointer names the preferred source, and after each contested grant it moves to the loser; uncontested grants leave it unchanged.
- REQ-030: Macro RF_WB_ARB_RR_EN undefined: MEM has fixed priority. A saturating counter increments on each cycle ALU is valid and loses. When the counter equals STARVE_MAX, the next contested cycle grants ALU. The counter clears on any ALU grant.

Verification
- REQ-031: Reset mid-write: transfer alu reg=2 data=0xDEADBEEF, assert rst the next cycle -> write_en=0, busy_mask=0x00 after the edge.
- REQ-032: Single source: alu_valid=1 reg=5 data=0x12345678, mem idle -> alu_ready=1 same cycle; next cycle write_en=1, write_reg=5, write_data=0x12345678, busy_mask=0x20.
- REQ-033: RR contest (macro defined): both valid continuously from reset, reg alu=1 mem=1 -> grants ALU, MEM, ALU, MEM; write_data alternates accordingly; final reg1 content is the last granted.
- REQ-034: Fixed priority (macro undefined, STARVE_MAX=3): both valid continuously -> grant sequence MEM, MEM, MEM, ALU, MEM, MEM, MEM, ALU.
- REQ-035: Back-to-back throughput: mem valid for 8 consecutive cycles with reg 0..7 -> 8 consecutive write_en=1 cycles, busy_mask walking 0x01..0x80, no bubbles.
- REQ-036: Idle after traffic: valids drop -> write_en=0 next cycle, write_reg/write_data unchanged, busy_mask=0x00.
